lfsr_rng: RTL

Parametrised, multi-channel Fibonacci LFSR pseudo-random source. It supplies random words to downstream blocks of the fetal ECG pipeline, such as weight initialisation and dither/noise injection. This is the successor to the fixed 52-bit generator, with these additions:
- configurable width, taps and word cadence
- N parallel channels
- runtime seeding
- valid/ready output with back-pressure stall
- lock-up detection and recovery

---
 rtl/lfsr_pkg.sv | 51 +++++
 rtl/lfsr_core.sv | 47 ++++
 rtl/lfsr_rng.sv | 93 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the multi-channel LFSR source.
// Helpers work on a 64-bit carrier; callers pass the live width.
package lfsr_pkg;

  localparam int unsigned MAXW = 64;
  localparam int unsigned MAXW_L = $clog2(MAXW);

  localparam logic [51:0] LFSR52_TAPS = 52'h8_0000_0000_000D;
  localparam logic [51:0] LFSR52_SEED = 52'hF;

  typedef logic [MAXW-1:0] lfsr_word_t;

  function automatic lfsr_word_t width_mask(
    input int unsigned w
  );
    lfsr_word_t m;
    if (w >= MAXW) m = '1;
    else m = (lfsr_word_t'(1) << w) - lfsr_word_t'(1);
    return m;
  endfunction

  function automatic lfsr_word_t lfsr_step(
    input lfsr_word_t  state,
    input lfsr_word_t  taps,
    input int unsigned w
  );
    lfsr_word_t m;
    lfsr_word_t nxt;
    m   = width_mask(w);
    nxt = {state[MAXW-2:0], ^(state & taps & m)};
    return nxt & m;
  endfunction

  function automatic lfsr_word_t rotl(
    input lfsr_word_t  x,
    input int unsigned n,
    input int unsigned w
  );
    lfsr_word_t r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < w) begin
        j = (i + n) % w;
        r[MAXW_L'(j)] = x[MAXW_L'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One LFSR channel: state register, step, seed load, zero detect.
// An all-zero step result reloads the channel's default seed.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 52,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR52_TAPS),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(LFSR52_SEED),
  parameter int unsigned CH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] next_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] RST_VAL =
    WIDTH'(rotl(lfsr_word_t'(SEED), CH, WIDTH));

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] load_val;
  logic             zero;

  assign raw = WIDTH'(lfsr_step(lfsr_word_t'(state_q),
                                lfsr_word_t'(TAPS), WIDTH));
  assign zero     = (raw == '0);
  assign next_o   = zero ? RST_VAL : raw;
  assign zero_o   = step_i & ~load_i & zero;
  assign load_val = WIDTH'(rotl(lfsr_word_t'(seed_i), CH, WIDTH));

  always_comb begin
    state_d = state_q;
    if (load_i) state_d = load_val;
    else if (step_i) state_d = next_o;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RST_VAL;
    else state_q <= state_d;
  end

endmodule

// File: rtl/lfsr_rng.sv
// Multi-channel LFSR random word source with valid/ready output.
// Channels step in lockstep; a full word stalls on back-pressure.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 52,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR52_TAPS),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(LFSR52_SEED),
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned SHIFTS_PER_WORD = WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_data,
  output logic                      rnd_valid,
  input  logic                      rnd_ready,
  output logic [CHANNELS*WIDTH-1:0] rnd_data,
  output logic                      lock_err
);

  localparam int unsigned CW =
    (SHIFTS_PER_WORD > 1) ? $clog2(SHIFTS_PER_WORD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFTS_PER_WORD - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0] data_q;
  logic [CHANNELS*WIDTH-1:0] next_all;
  logic [CHANNELS-1:0]       zero_w;
  logic                      lock_q;
  logic [WIDTH-1:0]          seed_sel;
  logic                      last, free, step, publish, fire;

  assign seed_sel = (seed_data == '0) ? SEED : seed_data;
  assign last     = (cnt_q == CNT_LAST);
  assign free     = ~valid_q | rnd_ready;
  assign fire     = valid_q & rnd_ready;
  assign step     = ~seed_load & en & (~last | free);
  assign publish  = ~seed_load & en & last & free;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lfsr_core #(
      .WIDTH(WIDTH),
      .TAPS (TAPS),
      .SEED (SEED),
      .CH   (c)
    ) u_core (
      .clk   (clk),
      .reset (reset),
      .load_i(seed_load),
      .seed_i(seed_sel),
      .step_i(step),
      .next_o(next_all[c*WIDTH +: WIDTH]),
      .zero_o(zero_w[c])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (seed_load) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (publish) begin
      cnt_d   = '0;
      valid_d = 1'b1;
    end else begin
      if (step) cnt_d = cnt_q + CW'(1);
      if (fire) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      if (publish) data_q <= next_all;
      if (|zero_w) lock_q <= 1'b1;
    end
  end

  assign rnd_valid = valid_q;
  assign rnd_data  = data_q;
  assign lock_err  = lock_q;

endmodule
